// File: rtl/sms_pkg.sv
// Shared definitions for the SMS latch-card pulse driver.
//   chan_state_t : per-channel FSM state
//   chan_out_t   : bundle of one channel's outputs, packed for fan-in at the top
//   DEF_*        : default pulse / guard / master-reset widths in clk cycles
//   cnt_width    : counter width able to hold the largest of the three widths
package sms_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SET,
    CLR,
    GAP
  } chan_state_t;

  typedef struct packed {
    logic set_n;
    logic clr_n;
    logic busy;
    logic err;
    logic drop;
  } chan_out_t;

  localparam int unsigned DEF_PULSE_W = 4;
  localparam int unsigned DEF_GAP_W   = 2;
  localparam int unsigned DEF_MR_W    = 8;

  function automatic int unsigned cnt_width(int unsigned pulse_w, int unsigned gap_w,
                                            int unsigned mr_w);
    int unsigned m;
    m = pulse_w;
    if (gap_w > m) m = gap_w;
    if (mr_w > m) m = mr_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sms_latch_pulse_driver_if.sv
// Bus between the CPU control logic / card and the SMS latch pulse driver.
//   set_req, clr_req : per-channel one-cycle request strobes
//   fb               : per-channel latch true output read back from the card
//   err_clr          : one-cycle strobe clearing err and drop
//   set_n, clr_n     : per-channel active-low trigger pulses to the card
//   mr_n             : shared active-low master reset to the card
//   busy, err, drop  : per-channel status
// master: the environment side (control logic plus card read-back).
// slave : the pulse driver.
interface sms_latch_pulse_driver_if;

  logic [1:0] set_req;
  logic [1:0] clr_req;
  logic [1:0] fb;
  logic       err_clr;
  logic [1:0] set_n;
  logic [1:0] clr_n;
  logic       mr_n;
  logic [1:0] busy;
  logic [1:0] err;
  logic [1:0] drop;

  modport master (
    output set_req, clr_req, fb, err_clr,
    input  set_n, clr_n, mr_n, busy, err, drop
  );

  modport slave (
    input  set_req, clr_req, fb, err_clr,
    output set_n, clr_n, mr_n, busy, err, drop
  );

endinterface

// File: rtl/sms_latch_chan.sv
// One latch channel: request FSM, pulse/guard counter, feedback check and the
// sticky err/drop flags.
//   clk_i, reset_i : clock and synchronous active-high reset
//   init_done_i    : one-cycle pulse, master reset ends on this edge
//   set_req_i      : set request strobe
//   clr_req_i      : clear request strobe (dominates set_req_i)
//   fb_i           : latch true output from the card
//   err_clr_i      : clears err and drop
//   out_o          : set_n, clr_n, busy, err, drop for this channel
module sms_latch_chan
  import sms_pkg::*;
#(
  parameter int unsigned PULSE_W = DEF_PULSE_W,
  parameter int unsigned GAP_W   = DEF_GAP_W,
  parameter int unsigned CntW    = 4
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      init_done_i,
  input  logic      set_req_i,
  input  logic      clr_req_i,
  input  logic      fb_i,
  input  logic      err_clr_i,
  output chan_out_t out_o
);

  chan_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            was_set_q, was_set_d;  // polarity of the pulse being checked
  logic            err_q, err_d;
  logic            drop_q, drop_d;
  logic            err_set;
  logic            drop_set;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      was_set_q <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      was_set_q <= was_set_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    was_set_d = was_set_q;
    err_set   = 1'b0;
    unique case (state_q)
      INIT: begin
        if (init_done_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (clr_req_i) begin
          state_d   = CLR;
          cnt_d     = '0;
          was_set_d = 1'b0;
        end else if (set_req_i) begin
          state_d   = SET;
          cnt_d     = '0;
          was_set_d = 1'b1;
        end
      end
      SET, CLR: begin
        if (cnt_q == CntW'(PULSE_W - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CntW'(GAP_W - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_set = (fb_i != was_set_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Requests in INIT are swallowed silently; only a busy pulse/guard drops them.
  assign drop_set = (state_q == SET || state_q == CLR || state_q == GAP) &&
                    (set_req_i || clr_req_i);

  // A new event in the same cycle as err_clr wins.
  assign err_d  = (err_q & ~err_clr_i) | err_set;
  assign drop_d = (drop_q & ~err_clr_i) | drop_set;

  always_comb begin
    out_o.set_n = (state_q != SET);
    out_o.clr_n = (state_q != CLR);
    out_o.busy  = (state_q != IDLE);
    out_o.err   = err_q;
    out_o.drop  = drop_q;
  end

endmodule

// File: rtl/sms_latch_pulse_driver.sv
// Clocked driver for a two-latch SMS set/reset card. Turns request strobes into
// timed active-low trigger pulses, holds the card in master reset after reset
// release, and checks latch feedback after every pulse.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of sms_latch_pulse_driver_if (requests, feedback, status)
module sms_latch_pulse_driver
  import sms_pkg::*;
#(
  parameter int unsigned PULSE_W = DEF_PULSE_W,
  parameter int unsigned GAP_W   = DEF_GAP_W,
  parameter int unsigned MR_W    = DEF_MR_W
) (
  input logic                     clk,
  input logic                     reset,
  sms_latch_pulse_driver_if.slave bus
);

  localparam int unsigned CntW = cnt_width(PULSE_W, GAP_W, MR_W);

  logic [CntW-1:0] mr_cnt_q, mr_cnt_d;
  logic            mr_done_q, mr_done_d;
  logic            init_done;
  chan_out_t       chan0_out;
  chan_out_t       chan1_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      mr_cnt_q  <= '0;
      mr_done_q <= 1'b0;
    end else begin
      mr_cnt_q  <= mr_cnt_d;
      mr_done_q <= mr_done_d;
    end
  end

  // init_done fires on the edge that ends the MR_W-th low cycle, so mr_n rises
  // on the same edge the channels leave INIT.
  assign init_done = !mr_done_q && (mr_cnt_q == CntW'(MR_W - 1));

  always_comb begin
    mr_cnt_d  = mr_cnt_q;
    mr_done_d = mr_done_q;
    if (init_done) begin
      mr_done_d = 1'b1;
      mr_cnt_d  = '0;
    end else if (!mr_done_q) begin
      mr_cnt_d = mr_cnt_q + 1'b1;
    end
  end

  sms_latch_chan #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W),
    .CntW    (CntW)
  ) u_chan0 (
    .clk_i       (clk),
    .reset_i     (reset),
    .init_done_i (init_done),
    .set_req_i   (bus.set_req[0]),
    .clr_req_i   (bus.clr_req[0]),
    .fb_i        (bus.fb[0]),
    .err_clr_i   (bus.err_clr),
    .out_o       (chan0_out)
  );

  sms_latch_chan #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W),
    .CntW    (CntW)
  ) u_chan1 (
    .clk_i       (clk),
    .reset_i     (reset),
    .init_done_i (init_done),
    .set_req_i   (bus.set_req[1]),
    .clr_req_i   (bus.clr_req[1]),
    .fb_i        (bus.fb[1]),
    .err_clr_i   (bus.err_clr),
    .out_o       (chan1_out)
  );

  assign bus.mr_n  = mr_done_q;
  assign bus.set_n = {chan1_out.set_n, chan0_out.set_n};
  assign bus.clr_n = {chan1_out.clr_n, chan0_out.clr_n};
  assign bus.busy  = {chan1_out.busy, chan0_out.busy};
  assign bus.err   = {chan1_out.err, chan0_out.err};
  assign bus.drop  = {chan1_out.drop, chan0_out.drop};

endmodule

// File: tb/tb_sms_latch_pulse_driver.sv
// Scoreboard bench for sms_latch_pulse_driver: stimulus pushes the expected
// shape of every pulse (trigger low time, busy time, err after the check) into
// a per-channel queue; a negedge monitor measures each completed pulse and
// pops/compares. Status flags and the master-reset sequence are checked inline.
module tb_sms_latch_pulse_driver;

  typedef struct {
    int set_low;
    int clr_low;
    int busy_len;
    int err;
  } rec_t;

  logic clk;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  rec_t exp_q0[$];
  rec_t exp_q1[$];

  logic [1:0] latch;     // card latch model
  logic [1:0] stuck_en;
  logic [1:0] stuck_val;

  sms_latch_pulse_driver_if dut_if ();

  sms_latch_pulse_driver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!dut_if.mr_n) latch[c] <= 1'b0;
      else if (!dut_if.clr_n[c]) latch[c] <= 1'b0;
      else if (!dut_if.set_n[c]) latch[c] <= 1'b1;
    end
  end

  assign dut_if.fb = (stuck_en & stuck_val) | (~stuck_en & latch);

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int s_low, input int c_low, input int e);
    rec_t r;
    r.set_low  = s_low;
    r.clr_low  = c_low;
    r.busy_len = 6;
    r.err      = e;
    if (ch == 0) exp_q0.push_back(r);
    else exp_q1.push_back(r);
  endtask

  // One-cycle strobe; returns on the cycle after it was sampled.
  task automatic strobe(input logic [1:0] s, input logic [1:0] c, input logic ec);
    dut_if.set_req = s;
    dut_if.clr_req = c;
    dut_if.err_clr = ec;
    tick();
    dut_if.set_req = 2'b00;
    dut_if.clr_req = 2'b00;
    dut_if.err_clr = 1'b0;
  endtask

  // Returns on the first IDLE cycle of channel ch.
  task automatic wait_idle(input int ch, input string nm);
    int n;
    n = 0;
    while (dut_if.busy[ch] && n < 40) begin
      tick();
      n++;
    end
    if (dut_if.busy[ch]) chk({nm, "_idle_timeout"}, 1, 0);
  endtask

  // Counts master-reset low cycles (one already seen) and checks INIT outputs.
  task automatic init_seq(input string nm);
    int  lo;
    logic trig_ok;
    logic busy_ok;
    lo      = 1;
    trig_ok = 1'b1;
    busy_ok = 1'b1;
    while (!dut_if.mr_n && lo < 40) begin
      dut_if.set_req = (lo == 3) ? 2'b10 : 2'b00;
      dut_if.clr_req = (lo == 4) ? 2'b01 : 2'b00;
      tick();
      if (!dut_if.mr_n) begin
        lo++;
        if (dut_if.busy != 2'b11) busy_ok = 1'b0;
      end
      if (dut_if.set_n != 2'b11 || dut_if.clr_n != 2'b11) trig_ok = 1'b0;
    end
    dut_if.set_req = 2'b00;
    dut_if.clr_req = 2'b00;
    chk({nm, "_mr_low_cycles"}, lo, 8);
    chk({nm, "_busy_in_init"}, int'(busy_ok), 1);
    chk({nm, "_trig_high_in_init"}, int'(trig_ok), 1);
    chk({nm, "_busy_after_init"}, int'(dut_if.busy), 0);
    chk({nm, "_drop_after_init"}, int'(dut_if.drop), 0);
  endtask

  // Monitor: measure each pulse from busy rise to busy fall outside INIT.
  bit act[2];
  int bcnt[2];
  int scnt[2];
  int ccnt[2];

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!dut_if.set_n[c] && !dut_if.clr_n[c]) chk("both_triggers_low", 1, 0);
      if (!dut_if.mr_n) begin
        act[c] = 1'b0;
      end else if (dut_if.busy[c]) begin
        if (!act[c]) begin
          act[c]  = 1'b1;
          bcnt[c] = 0;
          scnt[c] = 0;
          ccnt[c] = 0;
        end
        bcnt[c]++;
        if (!dut_if.set_n[c]) scnt[c]++;
        if (!dut_if.clr_n[c]) ccnt[c]++;
      end else if (act[c]) begin
        rec_t r;
        act[c] = 1'b0;
        if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
          chk($sformatf("unexpected_pulse_ch%0d", c), 1, 0);
        end else begin
          if (c == 0) r = exp_q0.pop_front();
          else r = exp_q1.pop_front();
          chk($sformatf("set_low_ch%0d", c), scnt[c], r.set_low);
          chk($sformatf("clr_low_ch%0d", c), ccnt[c], r.clr_low);
          chk($sformatf("busy_len_ch%0d", c), bcnt[c], r.busy_len);
          chk($sformatf("err_after_ch%0d", c), int'(dut_if.err[c]), r.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    dut_if.set_req = 2'b00;
    dut_if.clr_req = 2'b00;
    dut_if.err_clr = 1'b0;
    stuck_en       = 2'b00;
    stuck_val      = 2'b00;

    // 1: reset state and master-reset sequence
    tick();
    chk("rst_set_n", int'(dut_if.set_n), 3);
    chk("rst_clr_n", int'(dut_if.clr_n), 3);
    chk("rst_mr_n", int'(dut_if.mr_n), 0);
    chk("rst_busy", int'(dut_if.busy), 3);
    chk("rst_err", int'(dut_if.err), 0);
    chk("rst_drop", int'(dut_if.drop), 0);
    reset = 1'b0;
    init_seq("init1");

    // 2: ch0 set pulse, feedback follows the latch
    push(0, 4, 0, 0);
    strobe(2'b01, 2'b00, 1'b0);
    chk("t2_busy_ch1", int'(dut_if.busy[1]), 0);
    wait_idle(0, "t2");
    chk("t2_err", int'(dut_if.err), 0);

    // 3: ch1 set+clr together, clear dominates
    push(1, 0, 4, 0);
    strobe(2'b10, 2'b10, 1'b0);
    wait_idle(1, "t3");

    // 4: second request while busy is dropped; err_clr clears drop
    push(0, 4, 0, 0);
    strobe(2'b01, 2'b00, 1'b0);
    tick();
    strobe(2'b01, 2'b00, 1'b0);
    chk("t4_drop_set", int'(dut_if.drop), 1);
    wait_idle(0, "t4");
    strobe(2'b00, 2'b00, 1'b1);
    chk("t4_drop_clr", int'(dut_if.drop), 0);

    // 5: clear with fb stuck at 1 sets sticky err
    stuck_en  = 2'b01;
    stuck_val = 2'b01;
    push(0, 0, 4, 1);
    strobe(2'b00, 2'b01, 1'b0);
    wait_idle(0, "t5");
    stuck_en = 2'b00;
    repeat (3) tick();
    chk("t5_err_sticky", int'(dut_if.err), 1);
    strobe(2'b00, 2'b00, 1'b1);
    chk("t5_err_clr", int'(dut_if.err), 0);

    // Request on the first IDLE cycle is accepted (minimum spacing)
    push(1, 0, 4, 0);
    push(1, 4, 0, 0);
    strobe(2'b00, 2'b10, 1'b0);
    wait_idle(1, "sp1");
    strobe(2'b10, 2'b00, 1'b0);
    chk("sp_busy_accept", int'(dut_if.busy[1]), 1);
    chk("sp_no_drop", int'(dut_if.drop), 0);
    wait_idle(1, "sp2");

    // New drop in the same cycle as err_clr: set wins
    push(0, 4, 0, 0);
    strobe(2'b01, 2'b00, 1'b0);
    tick();
    strobe(2'b01, 2'b00, 1'b1);
    chk("sw_drop_wins", int'(dut_if.drop), 1);
    wait_idle(0, "sw");

    // 6: reset on the 2nd cycle of a set pulse aborts it
    strobe(2'b01, 2'b00, 1'b0);
    chk("t6_set_low", int'(dut_if.set_n), 2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_set_n", int'(dut_if.set_n), 3);
    chk("t6_mr_n", int'(dut_if.mr_n), 0);
    chk("t6_busy", int'(dut_if.busy), 3);
    chk("t6_err", int'(dut_if.err), 0);
    chk("t6_drop", int'(dut_if.drop), 0);
    init_seq("init2");

    repeat (4) tick();
    chk("q0_left", exp_q0.size(), 0);
    chk("q1_left", exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
